// File: rtl/alu_dispatch_sched.sv
// alu_dispatch_sched: binds ready reservation-station entries round-robin to
// idle fixed-latency functional units, counts each unit down to completion
// and retires finished results onto the CDB one per cycle under a bus grant.
module alu_dispatch_sched #(
  parameter int ENTRIES = 4,
  parameter int NUM_FU  = 2,
  parameter int LATENCY = 3,
  parameter int TAG_W   = 4,
  localparam int IDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
  localparam int FU_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ENTRIES-1:0]        rs_ready,
  input  logic [ENTRIES*TAG_W-1:0]  rs_tag,
  input  logic                      flush,
  output logic [NUM_FU-1:0]         issue_valid,
  output logic [NUM_FU*IDX_W-1:0]   issue_idx,
  output logic [ENTRIES-1:0]        rs_clear,
  output logic [NUM_FU-1:0]         fu_busy,
  output logic                      cdb_req,
  input  logic                      cdb_gnt,
  output logic                      cdb_valid,
  output logic [FU_W-1:0]           cdb_fu,
  output logic [TAG_W-1:0]          cdb_tag
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    FU_IDLE = 2'd0,
    FU_RUN  = 2'd1,
    FU_DONE = 2'd2
  } fu_state_e;

  fu_state_e          fu_state_p1 [NUM_FU];
  logic [CNT_W-1:0]   fu_cnt_p1   [NUM_FU];
  logic [TAG_W-1:0]   fu_tag_p1   [NUM_FU];
  logic [IDX_W-1:0]   rr_ptr_p1;

  fu_state_e          fu_state_nx [NUM_FU];
  logic [CNT_W-1:0]   fu_cnt_nx   [NUM_FU];
  logic [TAG_W-1:0]   fu_tag_nx   [NUM_FU];
  logic [IDX_W-1:0]   rr_ptr_nx;
  logic [NUM_FU-1:0]  busy_nx;

  logic [NUM_FU-1:0]        grant_p0;
  logic [IDX_W-1:0]         grant_idx_p0 [NUM_FU];
  logic [NUM_FU*IDX_W-1:0]  grant_idx_flat_p0;
  logic [ENTRIES-1:0]       clear_p0;
  logic [NUM_FU-1:0]        done_p0;
  logic [NUM_FU-1:0]        cand_p0;
  logic [NUM_FU-1:0]        retire_p0;
  logic [FU_W-1:0]          retire_fu_p0;
  logic [TAG_W-1:0]         retire_tag_p0;

  // Entry index base+off, wrapping modulo ENTRIES (ENTRIES is a power of 2).
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    logic [31:0] sum;
    sum = 32'(base) + 32'(off);
    return sum[IDX_W-1:0];
  endfunction

  // ---- stage p0: select eligible entries round-robin and pair with idle FUs
  // Entries cleared last cycle are masked because the RS drops ready one cycle late.
  always_comb begin : sel_p0
    logic [ENTRIES-1:0] avail;
    logic               found;
    logic [IDX_W-1:0]   idx;
    avail             = rs_ready & ~rs_clear;
    grant_p0          = '0;
    clear_p0          = '0;
    rr_ptr_nx         = rr_ptr_p1;
    grant_idx_flat_p0 = '0;
    found             = 1'b0;
    idx               = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      grant_idx_p0[f] = '0;
      found           = 1'b0;
      if (!flush && fu_state_p1[f] == FU_IDLE) begin
        for (int k = 0; k < ENTRIES; k++) begin
          idx = wrap_idx(rr_ptr_p1, k);
          if (!found && avail[idx]) begin
            found           = 1'b1;
            grant_p0[f]     = 1'b1;
            grant_idx_p0[f] = idx;
            avail[idx]      = 1'b0;
            clear_p0[idx]   = 1'b1;
            rr_ptr_nx       = wrap_idx(idx, 1);
          end
        end
      end
      grant_idx_flat_p0[f*IDX_W +: IDX_W] = grant_idx_p0[f];
    end
  end

  // Retire candidate is the lowest-index DONE unit; it leaves only under grant.
  always_comb begin
    done_p0       = '0;
    cand_p0       = '0;
    retire_fu_p0  = '0;
    retire_tag_p0 = '0;
    for (int f = NUM_FU - 1; f >= 0; f--) begin
      if (fu_state_p1[f] == FU_DONE) begin
        done_p0[f]    = 1'b1;
        cand_p0       = '0;
        cand_p0[f]    = 1'b1;
        retire_fu_p0  = FU_W'(f);
        retire_tag_p0 = fu_tag_p1[f];
      end
    end
    retire_p0 = (cdb_gnt && !flush) ? cand_p0 : '0;
  end

  assign cdb_req = |done_p0;

  // Per-FU next state: IDLE -> RUN (countdown) -> DONE -> IDLE; flush kills all.
  always_comb begin
    busy_nx = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      fu_state_nx[f] = fu_state_p1[f];
      fu_cnt_nx[f]   = fu_cnt_p1[f];
      fu_tag_nx[f]   = fu_tag_p1[f];
      if (flush) begin
        fu_state_nx[f] = FU_IDLE;
        fu_cnt_nx[f]   = '0;
      end else begin
        unique case (fu_state_p1[f])
          FU_IDLE: begin
            if (grant_p0[f]) begin
              fu_tag_nx[f] = rs_tag[int'(grant_idx_p0[f])*TAG_W +: TAG_W];
              if (LATENCY == 1) begin
                fu_state_nx[f] = FU_DONE;
                fu_cnt_nx[f]   = '0;
              end else begin
                fu_state_nx[f] = FU_RUN;
                fu_cnt_nx[f]   = CNT_W'(LATENCY - 1);
              end
            end
          end
          FU_RUN: begin
            if (fu_cnt_p1[f] <= CNT_W'(1)) begin
              fu_state_nx[f] = FU_DONE;
              fu_cnt_nx[f]   = '0;
            end else begin
              fu_cnt_nx[f] = fu_cnt_p1[f] - CNT_W'(1);
            end
          end
          FU_DONE: begin
            if (retire_p0[f]) begin
              fu_state_nx[f] = FU_IDLE;
            end
          end
          default: begin
            fu_state_nx[f] = FU_IDLE;
            fu_cnt_nx[f]   = '0;
          end
        endcase
      end
      // A unit stays busy through the cycle its result is on the bus.
      busy_nx[f] = (fu_state_nx[f] != FU_IDLE) || retire_p0[f];
    end
  end

  // ---- stage p1: FU state, counters, captured tags and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < NUM_FU; f++) begin
        fu_state_p1[f] <= FU_IDLE;
        fu_cnt_p1[f]   <= '0;
        fu_tag_p1[f]   <= '0;
      end
      rr_ptr_p1 <= '0;
    end else begin
      for (int f = 0; f < NUM_FU; f++) begin
        fu_state_p1[f] <= fu_state_nx[f];
        fu_cnt_p1[f]   <= fu_cnt_nx[f];
        fu_tag_p1[f]   <= fu_tag_nx[f];
      end
      rr_ptr_p1 <= rr_ptr_nx;
    end
  end

  // Registered issue and CDB outputs; zeroed whenever not carrying a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid <= '0;
      issue_idx   <= '0;
      rs_clear    <= '0;
      fu_busy     <= '0;
      cdb_valid   <= 1'b0;
      cdb_fu      <= '0;
      cdb_tag     <= '0;
    end else begin
      issue_valid <= grant_p0;
      issue_idx   <= grant_idx_flat_p0;
      rs_clear    <= clear_p0;
      fu_busy     <= busy_nx;
      cdb_valid   <= |retire_p0;
      cdb_fu      <= (|retire_p0) ? retire_fu_p0 : '0;
      cdb_tag     <= (|retire_p0) ? retire_tag_p0 : '0;
    end
  end

endmodule
